mc_bus_responder: RTL and testbench

Synchronous responder for the MCU parallel memory bus (`mc_ce`/`mc_oe`/`mc_we`/`mc_add`/`mc_data`) that sits between the top-level pads and the register/command logic. It synchronises the asynchronous strobes into `clock`, qualifies them, and issues exactly one write strobe per MCU write cycle. For reads it fetches a word and drives it onto the data bus while the MCU holds OE low. It also flags illegal bus states.

---
 rtl/mc_bus_responder_pkg.sv | 16 +
 rtl/mc_bus_responder_sync.sv | 22 ++
 rtl/mc_bus_responder.sv | 117 +++++++++++
 tb/tb_mc_bus_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mc_bus_responder_pkg.sv
// Shared types and constants for the MCU parallel bus responder.
package mc_bus_responder_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    WR_QUAL,
    WR_HOLD,
    RD_FETCH,
    RD_DRIVE,
    ERROR
  } state_t;

endpackage

// File: rtl/mc_bus_responder_sync.sv
// Single-bit synchroniser for one asynchronous bus strobe; resets to a chosen level.
module sync_2ff
  import mc_bus_responder_pkg::*;
#(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_DEPTH-1:0] ff;

  always_ff @(posedge clock) begin
    if (!reset) ff <= {SYNC_DEPTH{RST_VAL}};
    else        ff <= {ff[SYNC_DEPTH-2:0], d};
  end

  assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/mc_bus_responder.sv
// MCU bus responder: synchronises CE/OE/WE, issues one write strobe per WE low,
// fetches and presents read data while OE is low, and flags WE+OE overlap.
module mc_bus_responder
  import mc_bus_responder_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  output logic                     wr_strobe,
  output logic [MC_ADD_WIDTH-1:0]  wr_add,
  output logic [MC_DATA_WIDTH-1:0] wr_data,
  output logic                     rd_strobe,
  output logic [MC_ADD_WIDTH-1:0]  rd_add,
  input  logic [MC_DATA_WIDTH-1:0] rd_data,
  output logic                     bus_error
);

  localparam int SW = $clog2(SYNC_DEPTH + 1);

  logic ce_s, oe_s, we_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_ce (.clock(clock), .reset(reset), .d(mc_ce), .q(ce_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_oe (.clock(clock), .reset(reset), .d(mc_oe), .q(oe_s));
  sync_2ff #(.RST_VAL(1'b1)) u_sync_we (.clock(clock), .reset(reset), .d(mc_we), .q(we_s));

  // The synchronisers come out of reset showing an idle bus regardless of the
  // pins, so RECOVER must not trust them until the reset value has flushed.
  logic [SW-1:0] settle;
  logic          flushed;

  always_ff @(posedge clock) begin
    if (!reset)                     settle <= '0;
    else if (!flushed)              settle <= settle + 1'b1;
  end

  assign flushed = (settle == SW'(SYNC_DEPTH));

  state_t state, state_n;
  logic   wr_fire, rd_fire, rd_cap, err;

  always_ff @(posedge clock) begin
    if (!reset) state <= RECOVER;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    rd_cap  = 1'b0;
    err     = 1'b0;
    if (!we_s && !oe_s) begin
      state_n = ERROR;
      err     = 1'b1;
    end else begin
      case (state)
        RECOVER:  if (flushed && we_s && oe_s) state_n = IDLE;
        IDLE: begin
          if (!ce_s && !we_s) state_n = WR_QUAL;
          else if (!ce_s && !oe_s) begin
            state_n = RD_FETCH;
            rd_fire = 1'b1;
          end
        end
        WR_QUAL: begin
          if (!ce_s && !we_s) begin
            state_n = WR_HOLD;
            wr_fire = 1'b1;
          end else state_n = IDLE;
        end
        WR_HOLD:  if (we_s) state_n = IDLE;
        RD_FETCH: begin
          rd_cap  = 1'b1;
          state_n = RD_DRIVE;
        end
        RD_DRIVE: if (oe_s || ce_s) state_n = IDLE;
        ERROR:    state_n = RECOVER;
        default:  state_n = RECOVER;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mc_data_out <= '0;
      mc_data_oe  <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_add      <= '0;
      wr_data     <= '0;
      rd_strobe   <= 1'b0;
      rd_add      <= '0;
      bus_error   <= 1'b0;
    end else begin
      wr_strobe  <= wr_fire;
      rd_strobe  <= rd_fire;
      // Pad drive follows residency in RD_DRIVE, so ERROR always drops it.
      mc_data_oe <= (state_n == RD_DRIVE);
      if (wr_fire) begin
        wr_add  <= mc_add;
        wr_data <= mc_data_in;
      end
      if (rd_fire) rd_add      <= mc_add;
      if (rd_cap)  mc_data_out <= rd_data;
      if (err)     bus_error   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_bus_responder.sv
// Directed bench for mc_bus_responder: write, back-to-back, read, glitch, error, reset-in-hold.
module tb_mc_bus_responder;
  import mc_bus_responder_pkg::*;

  logic        clock, reset;
  logic        mc_ce, mc_oe, mc_we;
  logic [5:0]  mc_add;
  logic [15:0] mc_data_in, mc_data_out;
  logic        mc_data_oe, wr_strobe, rd_strobe, bus_error;
  logic [5:0]  wr_add, rd_add;
  logic [15:0] wr_data, rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  mc_bus_responder #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) dut (
    .clock(clock), .reset(reset),
    .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
    .mc_add(mc_add), .mc_data_in(mc_data_in),
    .mc_data_out(mc_data_out), .mc_data_oe(mc_data_oe),
    .wr_strobe(wr_strobe), .wr_add(wr_add), .wr_data(wr_data),
    .rd_strobe(rd_strobe), .rd_add(rd_add), .rd_data(rd_data),
    .bus_error(bus_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational register-file read model.
  always_comb begin
    rd_data = 16'h1234;
    if (rd_add == 6'h03) rd_data = 16'hA55A;
  end

  always @(negedge clock) begin
    if (wr_strobe) wr_cnt++;
    if (rd_strobe) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full write cycle: setup 3 clocks, WE low 6 clocks, then 3 idle clocks.
  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    int c0;
    mc_add = a;
    mc_data_in = d;
    repeat (3) tick();
    c0 = wr_cnt;
    mc_ce = 1'b0;
    mc_we = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) begin
        chk("wr_strobe_edge4", wr_strobe, 1);
        chk("wr_add", wr_add, a);
        chk("wr_data", wr_data, d);
      end else begin
        chk("wr_strobe_quiet", wr_strobe, 0);
      end
    end
    mc_we = 1'b1;
    mc_ce = 1'b1;
    repeat (3) tick();
    chk("wr_one_strobe", wr_cnt - c0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data_oe"}, mc_data_oe, 0);
    chk({tag, "_data_out"}, mc_data_out, 0);
    chk({tag, "_wr_strobe"}, wr_strobe, 0);
    chk({tag, "_wr_add"}, wr_add, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_rd_strobe"}, rd_strobe, 0);
    chk({tag, "_rd_add"}, rd_add, 0);
    chk({tag, "_bus_error"}, bus_error, 0);
    chk({tag, "_state"}, dut.state, RECOVER);
  endtask

  initial begin
    int w0, r0;
    reset = 1'b0;
    mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b1;
    mc_add = '0; mc_data_in = '0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    repeat (4) tick();
    chk("idle_after_rst", dut.state, IDLE);

    // Single write
    do_write(6'h01, 16'h000B);

    // Eighteen back-to-back writes
    w0 = wr_cnt;
    for (int i = 0; i < 18; i++) do_write(6'h00, (i % 2 == 0) ? 16'h00FF : 16'h0000);
    chk("b2b_count", wr_cnt - w0, 18);

    // Read cycle
    r0 = rd_cnt;
    mc_add = 6'h03;
    repeat (3) tick();
    mc_ce = 1'b0;
    mc_oe = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 4) chk("rd_oe_low", mc_data_oe, 0);
      else       chk("rd_oe_high", mc_data_oe, 1);
      if (k == 3) begin
        chk("rd_strobe", rd_strobe, 1);
        chk("rd_add", rd_add, 6'h03);
      end
      if (k == 4) chk("rd_data_out", mc_data_out, 16'hA55A);
    end
    mc_oe = 1'b1;
    repeat (3) tick();
    chk("rd_oe_release", mc_data_oe, 0);
    mc_ce = 1'b1;
    repeat (3) tick();
    chk("rd_one_strobe", rd_cnt - r0, 1);

    // One-clock WE glitch
    w0 = wr_cnt;
    mc_ce = 1'b0;
    mc_we = 1'b0;
    tick();
    mc_we = 1'b1;
    mc_ce = 1'b1;
    repeat (5) tick();
    chk("glitch_no_strobe", wr_cnt - w0, 0);
    chk("glitch_idle", dut.state, IDLE);
    do_write(6'h02, 16'hBEEF);

    // WE and OE overlap
    w0 = wr_cnt;
    r0 = rd_cnt;
    mc_ce = 1'b0; mc_we = 1'b0; mc_oe = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("err_oe_off", mc_data_oe, 0);
    end
    chk("err_set", bus_error, 1);
    mc_ce = 1'b1; mc_we = 1'b1; mc_oe = 1'b1;
    repeat (6) tick();
    chk("err_sticky", bus_error, 1);
    chk("err_no_wr", wr_cnt - w0, 0);
    chk("err_no_rd", rd_cnt - r0, 0);
    chk("err_back_idle", dut.state, IDLE);

    // Reset while in WR_HOLD, released with WE still low
    mc_add = 6'h05;
    mc_data_in = 16'h1357;
    repeat (3) tick();
    mc_ce = 1'b0;
    mc_we = 1'b0;
    repeat (5) tick();
    chk("hold_reached", dut.state, WR_HOLD);
    reset = 1'b0;
    repeat (2) tick();
    chk_reset_vals("midrst");
    w0 = wr_cnt;
    reset = 1'b1;
    repeat (8) tick();
    chk("midrst_no_strobe", wr_cnt - w0, 0);
    chk("midrst_recover", dut.state, RECOVER);
    mc_we = 1'b1;
    mc_ce = 1'b1;
    repeat (4) tick();
    chk("midrst_idle", dut.state, IDLE);
    do_write(6'h07, 16'h2468);
    chk("midrst_one_strobe", wr_cnt - w0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
